debouncer: RTL and testbench

- Debounces one noisy, asynchronous 1-bit input, such as a push-button or switch, into a clean level in the clk domain.
- The input passes through a 2-flop synchronizer. A stability counter then drives the output.
- The output follows the synchronized input only after the input has held a new level for STABLE_CYCLES consecutive clocks.
- Sits between board-level inputs and the control logic that consumes them.

---
 rtl/debouncer.sv | 48 ++++
 tb/tb_debouncer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/debouncer.sv
// rtl/debouncer.sv - 2-flop synchronized, counter-based debouncer for one noisy input
module debouncer #(
    parameter int STABLE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam int CW = ($clog2(STABLE_CYCLES + 1) < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    generate
        if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
            $error("debouncer: STABLE_CYCLES must be >= 1");
        end
    endgenerate

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_out;

    // cnt only runs while sync2 disagrees with out; any agreement restarts the window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_out   <= 1'b0;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_out) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_out <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_debouncer.sv
// tb/tb_debouncer.sv - randomized and directed bench for debouncer at STABLE_CYCLES 1, 2 and 16
module tb_debouncer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in = 1'b1;
    logic out_1, out_2, out_16;

    int checks = 0;
    int errors = 0;

    localparam int NS [3] = '{1, 2, 16};

    bit smp [$];
    bit hist [$];
    bit out_m [3];

    debouncer #(.STABLE_CYCLES(1))  dut_1  (.clk(clk), .reset(reset), .in(in), .out(out_1));
    debouncer #(.STABLE_CYCLES(2))  dut_2  (.clk(clk), .reset(reset), .in(in), .out(out_2));
    debouncer #(.STABLE_CYCLES(16)) dut_16 (.clk(clk), .reset(reset), .in(in), .out(out_16));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        smp.delete();
        hist.delete();
        smp.push_back(1'b0);
        smp.push_back(1'b0);
        for (int k = 0; k < 3; k++) out_m[k] = 1'b0;
    endtask

    // out takes a new level once the last N decision-time samples all show that level
    task automatic model_edge(input bit v);
        bit s2;
        bit same;
        s2 = smp[smp.size() - 2];
        smp.push_back(v);
        hist.push_back(s2);
        if (smp.size() > 8) void'(smp.pop_front());
        if (hist.size() > 40) void'(hist.pop_front());
        for (int k = 0; k < 3; k++) begin
            if (hist.size() >= NS[k] && s2 != out_m[k]) begin
                same = 1'b1;
                for (int j = 1; j <= NS[k]; j++)
                    if (hist[hist.size() - j] != s2) same = 1'b0;
                if (same) out_m[k] = s2;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_out1"}, 8'(out_1), 8'(out_m[0]));
        chk({tag, "_out2"}, 8'(out_2), 8'(out_m[1]));
        chk({tag, "_out16"}, 8'(out_16), 8'(out_m[2]));
        chk({tag, "_cnt2_bound"}, 8'(dut_2.r_cnt <= 2'd1), 8'd1);
        chk({tag, "_cnt16_bound"}, 8'(dut_16.r_cnt <= 5'd15), 8'd1);
    endtask

    // called just after a rising edge; drives in, takes one edge, checks 1 time unit later
    task automatic step(input bit v, input string tag);
        in = v;
        @(posedge clk);
        model_edge(v);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_all({tag, "_during"});
        chk({tag, "_cnt2_clr"}, 8'(dut_2.r_cnt), 8'd0);
        chk({tag, "_cnt16_clr"}, 8'(dut_16.r_cnt), 8'd0);
        @(posedge clk);
        #1;
        check_all({tag, "_held"});
        #2 reset = 1'b0;
    endtask

    initial begin
        int edges;
        bit lvl;
        model_reset();

        // reset held with in=1: outputs stay 0
        @(posedge clk);
        #1;
        check_all("rst_in1");
        #2 in = 1'b0;
        reset = 1'b0;
        step(1'b0, "rst_rel");
        step(1'b0, "rst_rel2");

        for (int i = 0; i < 5; i++) begin
            step(i[0] ? 1'b0 : 1'b1, "chatter");
            chk("chatter_out2_low", 8'(out_2), 8'd0);
        end

        // rising: first edge sampling 1 is edge k, out_2 must rise after edge k+3
        step(1'b0, "pre_rise");
        edges = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, "rise");
            if (out_2 === 1'b1 && edges == 0) edges = i + 1;
        end
        chk("rise_latency2", 8'(edges), 8'd4);
        for (int i = 0; i < 14; i++) step(1'b1, "rise_hold");
        chk("rise_out16", 8'(out_16), 8'd1);

        step(1'b0, "short_low");
        for (int i = 0; i < 4; i++) step(1'b1, "short_back");
        chk("short_pulse_out2", 8'(out_2), 8'd1);
        edges = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, "fall");
            if (out_2 === 1'b0 && edges == 0) edges = i + 1;
        end
        chk("fall_latency2", 8'(edges), 8'd4);
        for (int i = 0; i < 16; i++) step(1'b0, "fall_hold");

        // 15-clock pulse is too short for STABLE_CYCLES=16
        for (int i = 0; i < 15; i++) step(1'b1, "pulse15");
        for (int i = 0; i < 20; i++) step(1'b0, "pulse15_end");
        chk("pulse15_out16", 8'(out_16), 8'd0);

        // reset one clock before out_2 would rise
        step(1'b1, "mid_k");
        step(1'b1, "mid_k1");
        step(1'b1, "mid_k2");
        chk("mid_cnt2", 8'(dut_2.r_cnt), 8'd1);
        async_reset("mid_rst");
        edges = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, "mid_rel");
            if (out_2 === 1'b1 && edges == 0) edges = i + 1;
        end
        chk("mid_rel_latency2", 8'(edges), 8'd4);

        // random runs of levels with occasional chatter and async resets
        lvl = 1'b1;
        for (int r = 0; r < 120; r++) begin
            int len;
            len = $urandom_range(1, 20);
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < len; i++) step(1'($urandom), "rnd_chat");
            end else begin
                lvl = ~lvl;
                for (int i = 0; i < len; i++) step(lvl, "rnd_run");
            end
            if ($urandom_range(0, 24) == 0) async_reset("rnd_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
